// File: rtl/fa_rca.sv
// Registered N-bit ripple-carry adder: {carry,sum} = a + b + cin, one cycle of latency.
// The combinational datapath is a generate-built chain of 1-bit full-adder cells.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_c,
    output logic co_c
);
    logic p;

    // Propagate term shared by the sum and the carry.
    assign p    = a ^ b;
    assign s_c  = p ^ ci;
    assign co_c = (a & b) | (ci & p);
endmodule

module fa_rca #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    output logic [N-1:0] sum,
    output logic         carry
);
    logic [N:0]   c;
    logic [N-1:0] s;

    assign c[0] = cin;

    // Carry ripples from bit 0 upward; no lookahead.
    for (genvar i = 0; i < int'(N); i++) begin : g_cell
        fa_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .ci   (c[i]),
            .s_c  (s[i]),
            .co_c (c[i+1])
        );
    end

    // Result register: loads on in_valid, otherwise holds while out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= s;
                carry <= c[N];
            end
        end
    end
endmodule

// File: tb/tb_fa_rca.sv
// Bench for fa_rca: directed N=5 table plus randomized checks on N=1, 4, 5 and 16
// against an arithmetic reference model.

module tb_fa_rca;
    localparam int unsigned NDUT = 4;

    typedef struct {
        logic       v;
        logic [4:0] a;
        logic [4:0] b;
        logic       cin;
        logic [4:0] es;
        logic       ec;
        logic       ev;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        rv [NDUT];
    logic [15:0] ra [NDUT];
    logic [15:0] rb [NDUT];
    logic        rc [NDUT];

    logic        v1, v4, v5, v16;
    logic        c1, c4, c5, c16;
    logic [0:0]  s1;
    logic [3:0]  s4;
    logic [4:0]  s5;
    logic [15:0] s16;

    logic [31:0] gsum [NDUT];
    logic        gc   [NDUT];
    logic        gv   [NDUT];

    int unsigned wid [NDUT];
    int unsigned exp_sum [NDUT];
    logic        exp_c   [NDUT];
    logic        exp_v   [NDUT];

    int nvec;
    int nfail;

    fa_rca #(.N(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv[0]), .a(ra[0][0:0]), .b(rb[0][0:0]),
        .cin(rc[0]), .out_valid(v1), .sum(s1), .carry(c1));
    fa_rca #(.N(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv[1]), .a(ra[1][3:0]), .b(rb[1][3:0]),
        .cin(rc[1]), .out_valid(v4), .sum(s4), .carry(c4));
    fa_rca #(.N(5)) u_n5 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv[2]), .a(ra[2][4:0]), .b(rb[2][4:0]),
        .cin(rc[2]), .out_valid(v5), .sum(s5), .carry(c5));
    fa_rca #(.N(16)) u_n16 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv[3]), .a(ra[3]), .b(rb[3]),
        .cin(rc[3]), .out_valid(v16), .sum(s16), .carry(c16));

    always_comb begin
        gsum[0] = 32'(s1);  gc[0] = c1;  gv[0] = v1;
        gsum[1] = 32'(s4);  gc[1] = c4;  gv[1] = v4;
        gsum[2] = 32'(s5);  gc[2] = c5;  gv[2] = v5;
        gsum[3] = 32'(s16); gc[3] = c16; gv[3] = v16;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk5(input string name, input logic [4:0] es, input logic ec, input logic ev);
        chk({name, ".sum"},       32'(s5), 32'(es));
        chk({name, ".carry"},     32'(c5), 32'(ec));
        chk({name, ".out_valid"}, 32'(v5), 32'(ev));
    endtask

    vec_t tbl [10];

    initial begin
        nvec  = 0;
        nfail = 0;
        wid[0] = 1; wid[1] = 4; wid[2] = 5; wid[3] = 16;
        for (int k = 0; k < int'(NDUT); k++) begin
            rv[k] = 1'b0; ra[k] = '0; rb[k] = '0; rc[k] = 1'b0;
        end

        //            v     a         b         cin   sum       carry valid
        tbl[0] = '{1'b1, 5'b10100, 5'b10010, 1'b0, 5'b00110, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 5'b11001, 5'b10001, 1'b1, 5'b01011, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 5'b00110, 5'b00110, 1'b1, 5'b01101, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 5'b11010, 5'b00000, 1'b1, 5'b11011, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 5'b01000, 5'b01001, 1'b0, 5'b10001, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 5'b00101, 5'b01010, 1'b0, 5'b11111, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk5("reset", 5'b00000, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Directed table on the N=5 instance.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rv[2] = tbl[i].v;
            ra[2] = 16'(tbl[i].a);
            rb[2] = 16'(tbl[i].b);
            rc[2] = tbl[i].cin;
            @(posedge clk);
            #1 chk5($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ec, tbl[i].ev);
        end

        // Asynchronous reset mid-cycle while in_valid is high.
        @(negedge clk);
        rv[2] = 1'b1; ra[2] = 16'h001f; rb[2] = 16'h001f; rc[2] = 1'b1;
        @(posedge clk);
        #1 chk5("pre_reset", 5'b11111, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk5("async_reset", 5'b00000, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk5("reset_held", 5'b00000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rv[2] = 1'b0;
        @(posedge clk);
        #1 chk5("post_release", 5'b00000, 1'b0, 1'b0);

        // Randomized phase on all widths, model holds last accepted result.
        for (int k = 0; k < int'(NDUT); k++) begin
            exp_sum[k] = 0; exp_c[k] = 1'b0; exp_v[k] = 1'b0;
        end
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            for (int k = 0; k < int'(NDUT); k++) begin
                int unsigned mask;
                int unsigned full;
                mask  = (32'h1 << wid[k]) - 1;
                rv[k] = ($urandom_range(0, 3) != 0);
                ra[k] = ($urandom_range(0, 15) == 0) ? 16'(mask) : 16'($urandom & mask);
                rb[k] = ($urandom_range(0, 15) == 0) ? 16'(mask) : 16'($urandom & mask);
                rc[k] = 1'($urandom_range(0, 1));
                if (rv[k]) begin
                    full       = 32'(ra[k]) + 32'(rb[k]) + 32'(rc[k]);
                    exp_sum[k] = full & mask;
                    exp_c[k]   = 1'((full >> wid[k]) & 1);
                end
                exp_v[k] = rv[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < int'(NDUT); k++) begin
                chk($sformatf("rnd_n%0d_sum", wid[k]),   gsum[k],      32'(exp_sum[k]));
                chk($sformatf("rnd_n%0d_carry", wid[k]), 32'(gc[k]),   32'(exp_c[k]));
                chk($sformatf("rnd_n%0d_valid", wid[k]), 32'(gv[k]),   32'(exp_v[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
